// File: rtl/demux_pkg.sv
// Shared types for the TDM receive demux: default lane count, slot index and lock FSM state.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the demux consumes every qualified beat and never stalls its source.
package demux_pkg;

    localparam int NUM_LANES_DEF = 8;
    localparam int SEL_W_DEF     = $clog2(NUM_LANES_DEF);

    // Slot index for the default lane count.
    typedef logic [SEL_W_DEF-1:0] slot_t;

    // HUNT waits for a frame-sync beat; LOCKED tracks slot position frame by frame.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/demux_slot_ctr.sv
// Slot counter and HUNT/LOCKED framing FSM for the TDM demux; decides where each beat lands.
// Latency: store_en/wr_slot/frame_end are combinational on the beat; sync_err/locked/cur_slot registered (1 cycle).
// Backpressure: none; cycles with din_valid=0 freeze counter and state.
// Optional: DEMUX_SLOT_OUT_EN exposes the slot counter as cur_slot.
module demux_slot_ctr
    import demux_pkg::*;
#(
    parameter  int NUM_LANES = NUM_LANES_DEF,
    localparam int SEL_W     = $clog2(NUM_LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [SEL_W-1:0] wr_slot,
    output logic             store_en,
    output logic             frame_end,
    output logic             sync_err,
    output logic             locked
`ifdef DEMUX_SLOT_OUT_EN
    ,
    output logic [SEL_W-1:0] cur_slot
`endif
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_LANES - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] slot_q, slot_d;
    logic             err_d;

    // State, slot counter and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            slot_q   <= '0;
            sync_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            sync_err <= err_d;
        end
    end

    // Next-state, next-slot and per-beat store decisions.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        err_d     = 1'b0;
        store_en  = 1'b0;
        frame_end = 1'b0;
        // A sync beat always lands in slot 0, including an early sync that restarts the frame.
        wr_slot   = frame_sync ? '0 : slot_q;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        store_en = 1'b1;
                        slot_d   = SEL_W'(1);
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // Sync away from slot 0 means the partial frame is abandoned.
                        store_en = 1'b1;
                        slot_d   = SEL_W'(1);
                        err_d    = (slot_q != '0);
                    end else if (slot_q == '0) begin
                        // Missing sync where a frame must start: lose lock, drop the beat.
                        err_d   = 1'b1;
                        state_d = HUNT;
                        slot_d  = '0;
                    end else begin
                        store_en  = 1'b1;
                        slot_d    = slot_q + 1'b1;
                        frame_end = (slot_q == LAST_SLOT);
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                end
            endcase
        end
    end

    assign locked = (state_q == LOCKED);

`ifdef DEMUX_SLOT_OUT_EN
    assign cur_slot = slot_q;
`endif

endmodule

// File: rtl/demux_1x8_tdm.sv
// TDM serial-to-lane demux: spreads successive beats over NUM_LANES lanes, publishes whole frames.
// Latency: 1 cycle from beat to lane_q; 1 cycle from last-slot beat to frame_q/frame_valid.
// Backpressure: none; din_valid=0 cycles are gaps that hold all state. Optional: DEMUX_SLOT_OUT_EN adds cur_slot.
module demux_1x8_tdm
    import demux_pkg::*;
#(
    parameter  int NUM_LANES = NUM_LANES_DEF,
    parameter  int DATA_W    = 1,
    localparam int SEL_W     = $clog2(NUM_LANES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        din_valid,
    input  logic [DATA_W-1:0]           din,
    input  logic                        frame_sync,
    output logic [NUM_LANES*DATA_W-1:0] lane_q,
    output logic [NUM_LANES*DATA_W-1:0] frame_q,
    output logic                        frame_valid,
    output logic                        sync_err,
    output logic                        locked
`ifdef DEMUX_SLOT_OUT_EN
    ,
    output logic [SEL_W-1:0]            cur_slot
`endif
);

    localparam int SHADOW_W = (NUM_LANES - 1) * DATA_W;

    logic [SEL_W-1:0]    wr_slot;
    logic                store_en;
    logic                frame_end;
    // Lanes 0..NUM_LANES-2 of the frame in progress; the last lane comes straight from din.
    logic [SHADOW_W-1:0] shadow;

    demux_slot_ctr #(
        .NUM_LANES (NUM_LANES)
    ) u_slot_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .wr_slot    (wr_slot),
        .store_en   (store_en),
        .frame_end  (frame_end),
        .sync_err   (sync_err),
        .locked     (locked)
`ifdef DEMUX_SLOT_OUT_EN
        ,
        .cur_slot   (cur_slot)
`endif
    );

    // Live view: write the accepted beat into its lane, other lanes hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
        end else if (store_en) begin
            lane_q[int'(wr_slot)*DATA_W +: DATA_W] <= din;
        end
    end

    // Shadow copy of the current frame's lower lanes, feeding the snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (store_en && (int'(wr_slot) < NUM_LANES - 1)) begin
            shadow[int'(wr_slot)*DATA_W +: DATA_W] <= din;
        end
    end

    // Snapshot on the last-slot beat; frame_valid pulses for one cycle alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q     <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_end;
            if (frame_end) begin
                frame_q <= {din, shadow};
            end
        end
    end

endmodule

// File: tb/tb_demux_1x8_tdm.sv
// Self-checking bench for demux_1x8_tdm: directed framing scenarios plus randomized beats vs a frame-level model.
// Latency: outputs compared every negedge against the model's post-edge view.
// Backpressure: n/a; the bench inserts random din_valid gaps.
module tb_demux_1x8_tdm;

    localparam int N  = 8;
    localparam int DW = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         din_valid;
    logic [DW-1:0] din;
    logic         frame_sync;
    logic [N*DW-1:0] lane_q;
    logic [N*DW-1:0] frame_q;
    logic         frame_valid;
    logic         sync_err;
    logic         locked;
`ifdef DEMUX_SLOT_OUT_EN
    logic [2:0]   cur_slot;
`endif

    always #5 clk = ~clk;

    demux_1x8_tdm #(
        .NUM_LANES (N),
        .DATA_W    (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din_valid   (din_valid),
        .din         (din),
        .frame_sync  (frame_sync),
        .lane_q      (lane_q),
        .frame_q     (frame_q),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked)
`ifdef DEMUX_SLOT_OUT_EN
        ,
        .cur_slot    (cur_slot)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level view of where beats go and what the outputs show after each edge.
    bit         m_locked = 1'b0;
    int         m_slot   = 0;
    logic [N-1:0] m_lane  = '0;
    logic [N-1:0] m_frame = '0;
    bit         m_fv     = 1'b0;
    bit         m_err    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked = 1'b0;
            m_slot   = 0;
            m_lane   = '0;
            m_frame  = '0;
            m_fv     = 1'b0;
            m_err    = 1'b0;
        end else begin
            m_fv  = 1'b0;
            m_err = 1'b0;
            if (din_valid === 1'b1) begin
                if (!m_locked) begin
                    if (frame_sync) begin
                        m_lane[0] = din[0];
                        m_slot    = 1;
                        m_locked  = 1'b1;
                    end
                end else if (frame_sync) begin
                    if (m_slot != 0) m_err = 1'b1;
                    m_lane[0] = din[0];
                    m_slot    = 1;
                end else if (m_slot == 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    m_lane[m_slot] = din[0];
                    if (m_slot == N - 1) begin
                        m_frame = m_lane;
                        m_fv    = 1'b1;
                    end
                    m_slot = (m_slot + 1) % N;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("lane_q", lane_q, m_lane);
            chk("frame_q", frame_q, m_frame);
            chk("frame_valid", frame_valid, m_fv);
            chk("sync_err", sync_err, m_err);
            chk("locked", locked, m_locked);
            chk("pulse_exclusive", frame_valid & sync_err, 0);
`ifdef DEMUX_SLOT_OUT_EN
            chk("cur_slot", cur_slot, m_slot);
`endif
        end
    end

    // One beat, presented from one negedge to the next.
    task automatic beat(input logic d, input logic s);
        din_valid  = 1'b1;
        din        = d;
        frame_sync = s;
        @(negedge clk);
        din_valid  = 1'b0;
        din        = '0;
        frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] pat;
    logic [7:0] pat2;

    initial begin
        rst_n      = 1'b0;
        din_valid  = 1'b0;
        din        = '0;
        frame_sync = 1'b0;
        pat        = 8'b0100_1101;
        pat2       = 8'b0101_1101;
        @(negedge clk);
        chk_en = 1'b1;

        // Beats during reset are ignored.
        repeat (4) beat(1'($urandom % 2), 1'b1);
        chk("rst_lane_q", lane_q, 0);
        chk("rst_frame_q", frame_q, 0);
        chk("rst_locked", locked, 0);

        // Out of reset, non-sync beats are dropped in HUNT.
        rst_n = 1'b1;
        repeat (3) beat(1'b1, 1'b0);
        chk("hunt_lane_q", lane_q, 0);
        chk("hunt_locked", locked, 0);

        // Clean back-to-back frame.
`ifdef DEMUX_SLOT_OUT_EN
        chk("cur_slot_start", cur_slot, 0);
`endif
        for (int i = 0; i < 8; i++) begin
            beat(pat[i], i == 0);
`ifdef DEMUX_SLOT_OUT_EN
            chk("cur_slot_seq", cur_slot, (i + 1) % 8);
`endif
            if (i < 7) chk("fv_early", frame_valid, 0);
        end
        chk("frame1_fv", frame_valid, 1);
        chk("frame1_q", frame_q, 8'h4D);
        idle(1);
        chk("frame1_fv_drop", frame_valid, 0);
        chk("frame1_hold", frame_q, 8'h4D);

        // Same frame with 2-cycle gaps between beats.
        for (int i = 0; i < 8; i++) begin
            beat(pat[i], i == 0);
            if (i < 7) begin
                chk("gap_fv_early", frame_valid, 0);
                idle(2);
            end
        end
        chk("gap_fv", frame_valid, 1);
        chk("gap_q", frame_q, 8'h4D);

        // Early sync at slot 3, then a fresh frame completes.
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        beat(pat2[0], 1'b1);
        chk("early_err", sync_err, 1);
        chk("early_fv", frame_valid, 0);
        chk("early_locked", locked, 1);
        idle(1);
        chk("early_err_pulse", sync_err, 0);
        for (int i = 1; i < 8; i++) beat(pat2[i], 1'b0);
        chk("resync_fv", frame_valid, 1);
        chk("resync_q", frame_q, 8'h5D);

        // Missing sync at slot 0 drops lock; later plain beats are ignored.
        beat(1'b0, 1'b0);
        chk("miss_err", sync_err, 1);
        chk("miss_locked", locked, 0);
        chk("miss_lane_hold", lane_q, 8'h5D);
        repeat (3) beat(1'b0, 1'b0);
        chk("miss_ignored", lane_q, 8'h5D);
        chk("miss_still_hunt", locked, 0);

        // Reset mid-frame clears immediately.
        beat(1'b1, 1'b1);
        repeat (4) beat(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_lane_q", lane_q, 0);
        chk("midrst_frame_q", frame_q, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_fv", frame_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic: mostly well-framed, with occasional sync faults and gaps.
        repeat (3000) begin
            if ($urandom % 4 == 0) begin
                idle(1);
            end else if (m_slot == 0) begin
                beat(1'($urandom % 2), ($urandom % 10) != 0);
            end else begin
                beat(1'($urandom % 2), ($urandom % 25) == 0);
            end
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1x8_tdm.md
Name: demux_1x8_tdm

Overview:
- Receive-side counterpart of the team's 8:1 mux tree: takes one time-division-multiplexed serial stream and distributes successive beats to 8 output lanes.
- Tracks slot position with a frame-sync marker and a slot counter.
- Exposes two views: live per-lane registers, and a frame snapshot with a valid strobe.
- Sits at the far end of any link fed by a mux_8x1-style slot selector.

Parameters:
- NUM_LANES, 8, lanes per frame; power of two, minimum 2.
- SEL_W, $clog2(NUM_LANES), slot index width; derived, not overridden.
- DATA_W, 1, width of each beat/lane.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din_valid  input  1  beat present on din this cycle.
- din  input  DATA_W  serial beat data.
- frame_sync  input  1  qualified by din_valid; marks the beat as slot 0.
- lane_q  output  NUM_LANES*DATA_W  live demux registers; lane s at bits [s*DATA_W +: DATA_W].
- frame_q  output  NUM_LANES*DATA_W  snapshot of the last complete frame.
- frame_valid  output  1  one-cycle pulse when frame_q updates.
- sync_err  output  1  one-cycle pulse on framing violation.
- locked  output  1  high in LOCKED state.

Behaviour:
- Reset (async assert, sync-released on clk): lane_q=0, frame_q=0, shadow=0, slot=0, frame_valid=0, sync_err=0, locked=0, state=HUNT.
- Only cycles with din_valid=1 are beats. With din_valid=0, the counter, state and all registers hold, and the pulses are 0. Gaps inside a frame are legal.
- HUNT:
  - Beats without frame_sync are dropped.
  - A beat with frame_sync: store as slot 0, slot becomes 1, go LOCKED.
- LOCKED, beat at slot s≠0 with frame_sync=0: store to lane s; slot becomes s+1, wrapping NUM_LANES-1 -> 0.
- LOCKED, beat at slot 0 with frame_sync=1: normal frame start; store, slot becomes 1.
- LOCKED, beat at slot 0 with frame_sync=0:
  - sync_err=1 next cycle; beat dropped; go HUNT; locked=0.
  - lane_q keeps its old contents.
- LOCKED, beat at slot s≠0 with frame_sync=1 (early sync):
  - sync_err=1 next cycle; partial frame discarded, so no frame_valid.
  - Beat is stored as slot 0; slot becomes 1; stay LOCKED.
- Store:
  - lane_q[s] and shadow[s] update on the clock edge of the beat, so lane_q is visible 1 cycle after the beat.
  - Other lanes hold.
- Frame completion:
  - On the beat at slot NUM_LANES-1, frame_q <= {din, shadow[NUM_LANES-2:0]}, with frame_valid=1 in the following cycle.
  - Latency is 1 cycle from the last beat to frame_q/frame_valid.
  - frame_q holds until the next complete frame.
- frame_valid and sync_err are never both 1 in the same cycle.
- Reset mid-frame aborts all state immediately; no pulse is emitted.
- Outputs are fully registered; there is no combinational din-to-output path.

Optional Feature:
- Macro: DEMUX_SLOT_OUT_EN.
- Defined: adds output port cur_slot, SEL_W bits, giving the slot index the next beat will occupy. Reset value is 0; it returns to 0 on entering HUNT.
- Undefined: the port is absent and the slot counter stays internal; all other behaviour is identical.

Decomposition:
- Package demux_pkg holds:
  - NUM_LANES_DEF=8, the slot index typedef slot_t (logic [SEL_W-1:0]).
  - The state enum state_t {HUNT, LOCKED}.
- One sub-module: demux_slot_ctr.
  - Contains the slot counter and the HUNT/LOCKED FSM.
  - Outputs slot, store_en, frame_end and sync_err.
- The top-level holds the lane, shadow and frame registers.

Test Plan:
- Reset: hold rst_n=0 while driving beats -> all outputs 0, locked=0. Release, then 3 beats din=1 with no sync -> lane_q=0, locked=0.
- Sync, then 8 beats din=1,0,1,1,0,0,1,0 (slots 0..7) -> frame_q=8'b0100_1101, frame_valid high for exactly one cycle, 1 cycle after the slot-7 beat.
- Same frame with din_valid=0 gaps of 2 cycles between beats -> identical frame_q; frame_valid only after the 8th beat.
- Locked, frame_sync asserted on the slot-3 beat -> sync_err pulse, no frame_valid. Next 7 beats complete a new frame -> frame_valid.
- After a good frame, slot-0 beat without frame_sync -> sync_err, locked=0. Subsequent non-sync beats are ignored.
- Reset asserted after 5 beats -> immediate clear, no frame_valid. With DEMUX_SLOT_OUT_EN, cur_slot reads 0,1,...,7,0 across a frame.
